fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/rv32i_types.sv | 22 ++
 rtl/pc_register.sv | 38 +++
 rtl/fetch_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the RV32I front end: fetch FSM states and the IF/ID record.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// Request-PC register: reset to RESET_PC, load a new target, or step to the next word.
module pc_register
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h40000060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Load wins over increment so a redirect is never lost to a same-cycle accept.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, skid buffer for stalls,
// squash of in-flight responses on redirect, and the IF/ID pipeline register.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h40000060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  // Handshake: imem_read stays high with imem_address stable until imem_resp
  // pulses for one cycle; that cycle completes the single outstanding request.

  fetch_state_e state_q, state_d;
  if_id_t       if_id_q, if_id_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  logic [31:0]  req_pc;
  logic         pc_load;
  logic [31:0]  pc_load_val;
  logic         pc_inc;
  logic [31:0]  target;

  assign target = align_word(redirect_pc_i);

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .load_pc_i (pc_load_val),
    .inc_i     (pc_inc),
    .pc_o      (req_pc)
  );

  always_comb begin
    state_d      = state_q;
    if_id_d      = if_id_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pend_pc_d    = pend_pc_q;
    pc_load      = 1'b0;
    pc_load_val  = target;
    pc_inc       = 1'b0;
    imem_read    = 1'b1;

    case (state_q)
      FETCH: begin
        if (redirect_i) begin
          if_id_d.valid = 1'b0;
          if (imem_resp) begin
            pc_load = 1'b1;
          end else begin
            pend_pc_d = target;
            state_d   = SQUASH;
          end
        end else if (imem_resp) begin
          if (stall_i) begin
            skid_pc_d    = req_pc;
            skid_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            if_id_d = '{valid: 1'b1, pc: req_pc, instr: imem_rdata};
            pc_inc  = 1'b1;
          end
        end else if (!stall_i) begin
          if_id_d.valid = 1'b0;
        end
      end

      HOLD: begin
        imem_read = 1'b0;
        if (redirect_i) begin
          if_id_d.valid = 1'b0;
          pc_load       = 1'b1;
          state_d       = FETCH;
        end else if (!stall_i) begin
          if_id_d = '{valid: 1'b1, pc: skid_pc_q, instr: skid_instr_q};
          pc_inc  = 1'b1;
          state_d = FETCH;
        end
      end

      SQUASH: begin
        if_id_d.valid = 1'b0;
        if (redirect_i) begin
          pend_pc_d = target;
        end
        // A redirect arriving with the response is the newest target.
        if (imem_resp) begin
          pc_load     = 1'b1;
          pc_load_val = redirect_i ? target : pend_pc_q;
          state_d     = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      if_id_q      <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      if_id_q      <= if_id_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign imem_address = req_pc;
  assign pc_o         = if_id_q.pc;
  assign instr_o      = if_id_q.instr;
  assign valid_o      = if_id_q.valid;

endmodule
